// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-RAM port arbiter.
// State encoding and port index constants.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int P_CPU = 0;
  localparam int P_DBG = 1;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// On contention the port that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    if (&req) grant = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// CPU / loader arbiter for the single-port unified RAM.
// Round-robin grants, bounded lock, tagged read return.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int WIDTH    = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             lock_timeout,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);
  localparam int CW = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] CNT_TOP =
    CW'(LOCK_MAX - 1);

  state_t        state;
  logic          last;
  logic [CW-1:0] lock_cnt;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic          cnt_top;
  logic          rv0_q;
  logic          rv1_q;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .grant (pick)
  );

  always_comb begin
    gnt = 2'b00;
    case (state)
      ST_IDLE: gnt = pick;
      ST_OWN0: gnt[P_CPU] = req0;
      ST_OWN1: gnt[P_DBG] = req1;
      default: gnt = 2'b00;
    endcase
    if (reset) gnt = 2'b00;
  end

  assign gnt0    = gnt[P_CPU];
  assign gnt1    = gnt[P_DBG];
  assign cnt_top = (lock_cnt == CNT_TOP);

  assign lock_timeout = !reset && cnt_top &&
    ((state == ST_OWN0 && req0 && lock0) ||
     (state == ST_OWN1 && req1 && lock1));

  assign ram_en = gnt0 | gnt1;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        ram_we    = we0;
        ram_addr  = addr0;
        ram_wdata = wdata0;
      end
      gnt1: begin
        ram_we    = we1;
        ram_addr  = addr1;
        ram_wdata = wdata1;
      end
      default: ;
    endcase
  end

  // Gating with reset drops a read already in flight.
  assign rvalid0 = rv0_q & ~reset;
  assign rvalid1 = rv1_q & ~reset;
  assign rdata   = (rvalid0 | rvalid1) ?
                   ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      rv0_q <= gnt0 & ~we0;
      rv1_q <= gnt1 & ~we1;
      case (state)
        ST_IDLE: begin
          lock_cnt <= '0;
          if (req0 && req1) last <= gnt1;
          if (gnt0 && lock0)
            state <= ST_OWN0;
          else if (gnt1 && lock1)
            state <= ST_OWN1;
        end
        ST_OWN0: begin
          if (!cnt_top)
            lock_cnt <= lock_cnt + CW'(1);
          if (!req0 || !lock0) begin
            state <= ST_IDLE;
          end else if (cnt_top) begin
            state <= ST_IDLE;
            last  <= 1'b0;
          end
        end
        ST_OWN1: begin
          if (!cnt_top)
            lock_cnt <= lock_cnt + CW'(1);
          if (!req1 || !lock1) begin
            state <= ST_IDLE;
          end else if (cnt_top) begin
            state <= ST_IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
